limn2600_cache_ctrl: RTL

LIMN2600_CACHE_CTRL -- requirements
Module: limn2600_CacheCtrl

---
 rtl/limn2600_cache_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/limn2600_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with word-serial line fill.
// Define LIMN2600_CACHE_STATS_EN to add read hit/miss counters (hit_count, miss_count).
module limn2600_cache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef LIMN2600_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;

    state_t              state;
    logic [31:2]         addr_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic [OFF_W-1:0]    fill_cnt;
    logic                flush_pend;
    logic [LINES-1:0]    valid;

    logic [TAG_W-1:0]    tag_mem  [0:LINES-1];
    logic [31:0]         data_mem [0:LINES*WORDS-1];

    logic [OFF_W-1:0]    off_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic                hit;
    logic [31:0]         hit_word;
    logic                mem_take;
    logic                fill_last;

    logic                     data_we;
    logic [IDX_W+OFF_W-1:0]   data_waddr;
    logic [31:0]              data_wdata;
    logic                     tag_we;

    // Byte-lane bits carry no meaning for word accesses.
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

    assign off_q     = addr_q[2 +: OFF_W];
    assign idx_q     = addr_q[2+OFF_W +: IDX_W];
    assign tag_q     = addr_q[31 -: TAG_W];
    assign hit       = valid[idx_q] && (tag_mem[idx_q] == tag_q);
    assign hit_word  = data_mem[{idx_q, off_q}];
    assign mem_take  = mem_req && mem_ack;
    assign fill_last = (fill_cnt == OFF_W'(WORDS-1));

    always_comb begin
        data_we    = 1'b0;
        data_waddr = {idx_q, fill_cnt};
        data_wdata = mem_rdata;
        if (state == FILL && mem_take) begin
            data_we = 1'b1;
        end else if (state == WRITE && mem_take && hit) begin
            data_we    = 1'b1;
            data_waddr = {idx_q, off_q};
            data_wdata = wdata_q;
        end
    end

    assign tag_we = (state == FILL) && mem_take && fill_last;

    // Tag and data arrays hold no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_waddr] <= data_wdata;
        end
        if (tag_we) begin
            tag_mem[idx_q] <= tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            fill_cnt   <= '0;
            flush_pend <= 1'b0;
            valid      <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef LIMN2600_CACHE_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            if (state != IDLE && flush) begin
                flush_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // A flush owns the IDLE cycle; the request is taken on a later one.
                    if (flush || flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end else if (cpu_req) begin
                        addr_q  <= cpu_addr[31:2];
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {addr_q, 2'b00};
                        mem_wdata <= wdata_q;
                        state     <= WRITE;
                    end else if (hit) begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= hit_word;
                        state     <= RESP;
`ifdef LIMN2600_CACHE_STATS_EN
                        hit_count <= hit_count + 32'd1;
`endif
                    end else begin
                        // Line is invalid while refilling so an aborted fill never hits.
                        valid[idx_q] <= 1'b0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= {addr_q[31:2+OFF_W], {(OFF_W+2){1'b0}}};
                        fill_cnt     <= '0;
                        state        <= FILL;
`ifdef LIMN2600_CACHE_STATS_EN
                        miss_count   <= miss_count + 32'd1;
`endif
                    end
                end
                FILL: begin
                    if (mem_take) begin
                        if (fill_cnt == off_q) begin
                            cpu_rdata <= mem_rdata;
                        end
                        if (fill_last) begin
                            valid[idx_q] <= 1'b1;
                            mem_req      <= 1'b0;
                            cpu_ack      <= 1'b1;
                            state        <= RESP;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                WRITE: begin
                    if (mem_take) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    cpu_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
